// File: rtl/regfile_pkg.sv
// Shared widths, clear-sequencer state encoding and the hard-wired zero register
// address for the MIPS general-purpose register file.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   // Register $zero: reads always return 0 and writes are dropped.
   localparam int REG_ZERO = 0;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every register entry writing zero, then hands
// the array over to normal operation and drops busy.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   CLEAR | zeroing mem[ptr] each edge; busy high, user access blocked
//   READY | array owned by the datapath; only reset leaves this state
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] PTR_LAST = '1;

   rf_state_t         state;
   logic [ADDR_W-1:0] ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
         ptr   <= '0;
         busy  <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               // ptr wraps back to 0 on the last write; it is unused once READY.
               ptr <= ptr + ADDR_W'(1);
               if (ptr == PTR_LAST) begin
                  state <= READY;
                  busy  <= 1'b0;
               end
            end
            READY: begin
               state <= READY;
               busy  <= 1'b0;
            end
            default: begin
               state <= CLEAR;
               ptr   <= '0;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   assign clr_we   = (state == CLEAR);
   assign clr_addr = ptr;

endmodule

// File: rtl/register_file.sv
// 32x32 MIPS register file: one write port, two registered read ports with
// write-first bypass, and a post-reset sequencer that zeroes the array.
module register_file
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ard1,
   input  logic [ADDR_W-1:0] ard2,
   input  logic [ADDR_W-1:0] awr,
   input  logic [DATA_W-1:0] din,
   input  logic              we,
   output logic [DATA_W-1:0] dout1,
   output logic [DATA_W-1:0] dout2,
   output logic              busy
);

   localparam int                DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              user_we;
   logic [DATA_W-1:0] rd1_nxt;
   logic [DATA_W-1:0] rd2_nxt;

   regfile_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .busy     (busy)
   );

   // User writes only count once the clear has finished and never touch $zero.
   assign user_we = we && !clr_we && (awr != ZERO_ADDR);

   // The array has no reset; the sequencer owns it while clearing.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (user_we) begin
         mem[awr] <= din;
      end
   end

   always_comb begin
      rd1_nxt = mem[ard1];
      if (ard1 == ZERO_ADDR) begin
         rd1_nxt = '0;
      end else if (we && (awr == ard1)) begin
         rd1_nxt = din;
      end
   end

   always_comb begin
      rd2_nxt = mem[ard2];
      if (ard2 == ZERO_ADDR) begin
         rd2_nxt = '0;
      end else if (we && (awr == ard2)) begin
         rd2_nxt = din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout1 <= '0;
         dout2 <= '0;
      end else if (clr_we) begin
         dout1 <= '0;
         dout2 <= '0;
      end else begin
         dout1 <= rd1_nxt;
         dout2 <= rd2_nxt;
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_register_file;

   logic        clk;
   logic        rst_n;
   logic [4:0]  ard1;
   logic [4:0]  ard2;
   logic [4:0]  awr;
   logic [31:0] din;
   logic        we;
   logic [31:0] dout1;
   logic [31:0] dout2;
   logic        busy;

   int n_tests;
   int n_fail;

   logic [31:0] ref_mem [32];
   int          clear_left;

   register_file dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ard1  (ard1),
      .ard2  (ard2),
      .awr   (awr),
      .din   (din),
      .we    (we),
      .dout1 (dout1),
      .dout2 (dout2),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle's inputs, let the edge happen, compare against the model.
   task automatic cyc(input logic w, input logic [4:0] wa, input logic [31:0] d,
                      input logic [4:0] a1, input logic [4:0] a2);
      logic [31:0] e1, e2;
      logic        eb;
      we = w; awr = wa; din = d; ard1 = a1; ard2 = a2;
      @(posedge clk);
      if (clear_left > 0) begin
         e1 = 32'h0;
         e2 = 32'h0;
         clear_left--;
         eb = (clear_left > 0);
      end else begin
         e1 = (a1 == 5'd0) ? 32'h0 : ((w && wa == a1) ? d : ref_mem[a1]);
         e2 = (a2 == 5'd0) ? 32'h0 : ((w && wa == a2) ? d : ref_mem[a2]);
         if (w && wa != 5'd0) ref_mem[wa] = d;
         eb = 1'b0;
      end
      #1;
      chk("dout1", dout1, e1);
      chk("dout2", dout2, e2);
      chk("busy", {31'b0, busy}, {31'b0, eb});
      @(negedge clk);
   endtask

   // Asynchronous reset pulse dropped between edges; called at a negedge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_dout1", dout1, 32'h0);
      chk("rst_dout2", dout2, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h1);
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
      clear_left = 32;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      clear_left = 32;
      rst_n = 1'b1;
      we = 1'b0; awr = '0; din = '0; ard1 = '0; ard2 = '0;
      @(negedge clk);

      // 1: reset clear, busy for exactly 32 edges, every register reads zero
      do_reset();
      for (int i = 0; i < 32; i++) begin
         cyc(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
         chk("t1_busy", {31'b0, busy}, (i < 31) ? 32'h1 : 32'h0);
      end
      for (int r = 1; r < 32; r++) begin
         cyc(1'b0, 5'd0, 32'h0, 5'(r), 5'(32 - r));
         chk("t1_zero", dout1, 32'h0);
      end

      // 2: write then read on both ports
      cyc(1'b1, 5'd5, 32'h1, 5'd0, 5'd0);
      cyc(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      chk("t2_dout1", dout1, 32'h1);
      chk("t2_dout2", dout2, 32'h1);

      // 3: write-first bypass
      cyc(1'b1, 5'd7, 32'h7, 5'd7, 5'd5);
      chk("t3_bypass", dout1, 32'h7);
      cyc(1'b0, 5'd0, 32'h0, 5'd1, 5'd7);
      chk("t3_stored", dout2, 32'h7);

      // 4: WE low holds, writes to $zero dropped
      cyc(1'b0, 5'd7, 32'h40C06007, 5'd7, 5'd7);
      chk("t4_hold", dout1, 32'h7);
      cyc(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      chk("t4_r0_byp", dout1, 32'h0);
      cyc(1'b0, 5'd0, 32'h0, 5'd0, 5'd7);
      chk("t4_r0", dout1, 32'h0);
      chk("t4_r7", dout2, 32'h7);

      // 5: writes ignored while busy
      do_reset();
      for (int i = 0; i < 32; i++) begin
         cyc(1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3);
         chk("t5_dout1", dout1, 32'h0);
      end
      cyc(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
      chk("t5_r3", dout1, 32'h0);

      // 6: mid-run reset wipes contents
      cyc(1'b1, 5'd9, 32'hA5A5A5A5, 5'd0, 5'd0);
      cyc(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
      chk("t6_pre", dout1, 32'hA5A5A5A5);
      do_reset();
      for (int i = 0; i < 32; i++) cyc(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
      cyc(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
      chk("t6_r9", dout1, 32'h0);

      // randomized traffic, addresses biased low to hit bypass and collisions
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] a1, a2, wa;
         a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         if ($urandom_range(0, 499) == 0) do_reset();
         cyc(1'($urandom_range(0, 1)), wa, $urandom, a1, a2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
